// File: rtl/led_output_stage.sv
`default_nettype none
// ============================================================================
// Module      : led_output_stage
// Description : Output stage for the board LEDs. Registers the raw LED value
//               coming from the data memory LED register. Applies global PWM
//               dimming, with the duty written through a one-cycle strobe.
//               Stretches each rising bit into a visible flash that lasts
//               STRETCH_TICKS PWM ticks.
//               Runs on the free-running system clock.
//
// Ports       : clk_i      - system clock (undivided, not stall-gated)
//               reset_i    - synchronous, active-high reset
//               led_i      - raw 8-bit LED value
//               dim_we_i   - one-cycle strobe that loads the duty register
//               dim_i      - new duty value (PWM_W bits)
//               led_o      - registered drive to the physical LEDs
//               stretch_o  - per-bit flag: stretch counter is non-zero
//
// Revision    : 1.0 - initial release
// ============================================================================
module led_output_stage #(
   parameter int unsigned PRESCALE      = 16,
   parameter int unsigned PWM_W         = 4,
   parameter int unsigned STRETCH_TICKS = 8
) (
   input  logic             clk_i,
   input  logic             reset_i,
   input  logic [7:0]       led_i,
   input  logic             dim_we_i,
   input  logic [PWM_W-1:0] dim_i,
   output logic [7:0]       led_o,
   output logic [7:0]       stretch_o
);

   localparam int unsigned      c_pre_w        = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [c_pre_w-1:0] c_pre_last   = c_pre_w'(PRESCALE - 1);
   localparam logic [c_pre_w-1:0] c_pre_one    = c_pre_w'(1);
   localparam logic [PWM_W-1:0] c_pwm_one      = PWM_W'(1);
   localparam logic [PWM_W-1:0] c_duty_full    = '1;
   localparam logic [7:0]       c_stretch_load = 8'(STRETCH_TICKS);

   // ------------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------------
   logic [c_pre_w-1:0] prescale_q, prescale_d;
   logic [PWM_W-1:0]   pwm_cnt_q,  pwm_cnt_d;
   logic [PWM_W-1:0]   duty_q,     duty_d;
   logic [7:0]         led_q,      led_d;
   logic [7:0]         led_prev_q, led_prev_d;
   logic [7:0]         stretch_q [8];
   logic [7:0]         stretch_d [8];
   logic [7:0]         led_out_q,  led_out_d;
   logic [7:0]         str_out_q,  str_out_d;

   // ------------------------------------------------------------------------
   // Combinational helpers
   // ------------------------------------------------------------------------
   logic       w_tick;
   logic       w_pwm_on;
   logic [7:0] w_rise;
   logic [7:0] w_active;

   always_comb begin
      w_tick = (prescale_q == c_pre_last);
      w_rise = led_q & ~led_prev_q;
      // Full-scale duty is treated as always on so no off slot appears at
      // pwm_cnt == max; every other duty gives duty/2^PWM_W on-time.
      if (duty_q == c_duty_full) begin
         w_pwm_on = 1'b1;
      end else begin
         w_pwm_on = (pwm_cnt_q < duty_q);
      end
      for (int k = 0; k < 8; k++) begin
         w_active[k] = (stretch_q[k] != 8'd0);
      end
   end

   // ------------------------------------------------------------------------
   // Next-state logic
   // ------------------------------------------------------------------------
   always_comb begin
      led_d      = led_i;
      led_prev_d = led_q;

      if (w_tick) begin
         prescale_d = '0;
      end else begin
         prescale_d = prescale_q + c_pre_one;
      end

      // Wraps naturally from all-ones to zero.
      if (w_tick) begin
         pwm_cnt_d = pwm_cnt_q + c_pwm_one;
      end else begin
         pwm_cnt_d = pwm_cnt_q;
      end

      if (dim_we_i) begin
         duty_d = dim_i;
      end else begin
         duty_d = duty_q;
      end

      // A new rise reloads even an active counter, so a retrigger extends
      // the flash without a gap.
      for (int k = 0; k < 8; k++) begin
         if (w_rise[k]) begin
            stretch_d[k] = c_stretch_load;
         end else if (w_tick && w_active[k]) begin
            stretch_d[k] = stretch_q[k] - 8'd1;
         end else begin
            stretch_d[k] = stretch_q[k];
         end
      end

      led_out_d = w_active | (led_q & {8{w_pwm_on}});
      str_out_d = w_active;
   end

   // ------------------------------------------------------------------------
   // Registers
   // ------------------------------------------------------------------------
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         prescale_q <= '0;
         pwm_cnt_q  <= '0;
         duty_q     <= c_duty_full;
         led_q      <= 8'd0;
         led_prev_q <= 8'd0;
         led_out_q  <= 8'd0;
         str_out_q  <= 8'd0;
         for (int k = 0; k < 8; k++) begin
            stretch_q[k] <= 8'd0;
         end
      end else begin
         prescale_q <= prescale_d;
         pwm_cnt_q  <= pwm_cnt_d;
         duty_q     <= duty_d;
         led_q      <= led_d;
         led_prev_q <= led_prev_d;
         led_out_q  <= led_out_d;
         str_out_q  <= str_out_d;
         for (int k = 0; k < 8; k++) begin
            stretch_q[k] <= stretch_d[k];
         end
      end
   end

   assign led_o     = led_out_q;
   assign stretch_o = str_out_q;

endmodule
`default_nettype wire

// File: doc/led_output_stage.md
Name: led_output_stage

Overview:
- Sits directly downstream of the data memory's LED register. Consumes the raw 8-bit LED value written by the processor and drives the board LEDs.
- Adds global PWM dimming, software-written over a small config strobe.
- Adds per-bit activity pulse stretching, so a bit that rises only briefly still gives a visible flash.
- Runs on the undivided system clock, not the stall-gated processor clock.

Parameters:
- PRESCALE, 16, system clocks per PWM tick; legal range ≥ 2.
- PWM_W, 4, PWM counter and duty width; PWM period = 2^PWM_W ticks.
- STRETCH_TICKS, 8, PWM ticks a stretched bit is held fully on; must be in 1..255.

Ports:
- clk_i  in  1  system clock.
- reset_i  in  1  synchronous, active-high reset.
- led_i  in  8  raw LED value from the data memory LED register.
- dim_we_i  in  1  one-cycle strobe that loads the duty register.
- dim_i  in  PWM_W  new duty value, sampled when dim_we_i=1.
- led_o  out  8  registered drive to the physical LEDs.
- stretch_o  out  8  per-bit flag: stretch counter is non-zero.

Behaviour:
- Clock and reset: one clock, clk_i. reset_i is synchronous and active-high. It is sampled on the clk_i rising edge and dominates all other inputs in that cycle.
- Reset state:
  - prescaler = 0, pwm_cnt = 0, led_q = 0, led_prev = 0, all stretch counters = 0.
  - duty_q = 2^PWM_W−1 (full on).
  - led_o = 0, stretch_o = 0.
  - Reset asserted mid-stretch or mid-period clears everything at the next edge. No stretch survives reset.
- Input register: led_q <= led_i every cycle. led_prev <= led_q every cycle.
- Rise detect: rise[k] = led_q[k] & ~led_prev[k].
- Prescaler: counts 0..PRESCALE−1 and wraps to 0. tick = 1 in the cycle where prescaler == PRESCALE−1.
- PWM counter: pwm_cnt (PWM_W bits) increments on tick. It wraps from 2^PWM_W−1 to 0.
- Duty register: on dim_we_i=1, duty_q <= dim_i. The new value affects led_o computed from the next cycle onward. Write plus reset in the same cycle: reset wins.
- PWM enable:
  - pwm_on = 1 when duty_q == 2^PWM_W−1 (always on).
  - Otherwise pwm_on = (pwm_cnt < duty_q).
  - duty_q = 0 means always off.
- Stretch counter, per bit k, 8-bit:
  - rise[k] = 1: load STRETCH_TICKS. This takes priority over a decrement in the same cycle, so a retrigger reloads.
  - Else tick = 1 and counter ≠ 0: decrement by 1.
  - Otherwise hold. No underflow below 0.
- Output, registered:
  - led_o[k] <= (stretch[k] ≠ 0) | (led_q[k] & pwm_on).
  - stretch_o[k] <= (stretch[k] ≠ 0).
- Latency, from led_i change at edge N:
  - led_q updates at N+1; led_o reflects it at N+2 (2 cycles).
  - A rise seen in led_q at N+1 loads the counter at N+2; led_o and stretch_o go high at N+3.
- Stretch duration:
  - Counter ≠ 0 for STRETCH_TICKS ticks after the load, i.e. (STRETCH_TICKS−1)·PRESCALE to STRETCH_TICKS·PRESCALE clocks, depending on prescaler phase.
  - Afterwards the bit follows led_q & pwm_on.
- Falling bits do not stretch. A bit that stays high with full duty stays on continuously.
- All 8 bits share the prescaler, pwm_cnt and duty_q. The stretch counters are independent.

Test Plan:
- Reset held 3 cycles with led_i=8'hFF, then released → led_o=0 and stretch_o=0 while reset is held. After release, led_o goes 8'hFF by cycle N+3 (stretch from the rise), and stretch_o=8'hFF.
- Defaults, led_i=8'h01 steady for >1000 cycles after stretch expiry, dim_we_i pulse dim_i=4 → over one 256-clock period led_o[0] is high exactly 64 cycles, contiguous, starting when pwm_cnt=0. Other bits stay 0.
- dim_i=0 written, led_i=8'h0F steady (no stretch active) → led_o=0 continuously. dim_i=15 written → led_o=8'h0F continuously from 2 cycles after the write edge.
- duty=0, led_i bit 3 pulsed high for 1 cycle → stretch_o[3]=1 and led_o[3]=1 for between 112 and 128 clocks, then both 0. Other bits stay 0.
- duty=0, bit 3 re-pulsed 50 clocks into an active stretch → counter reloads to 8. Total on-time extends to ≥ 50+112 clocks from the first pulse. No gap in led_o[3].
- Reset asserted 40 clocks into a stretch, with dim_we_i=1 and dim_i=2 in the same cycle → next cycle led_o=0, stretch_o=0 and duty_q=15. The write is ignored.
